// File: rtl/pipe_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                        |
// | Shared state encoding and sizing for the pipeline hazard controller. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  localparam int INIT_CYCLES = 4;
  localparam int REG_ADDR_W  = 5;
  localparam int CNT_W       = 16;
  localparam int INIT_CNT_W  = $clog2(INIT_CYCLES);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// +----------------------------------------------------------------------+
// | hazard_detect                                                        |
// | Combinational load-use detection against all three ID source regs.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_idRs,
  input  logic [REG_ADDR_W-1:0] i_idRt,
  input  logic [REG_ADDR_W-1:0] i_idRs1c,
  input  logic                  i_exMemRead,
  input  logic [REG_ADDR_W-1:0] i_exRegDest,
  output logic                  o_loadUse
);

  // r0 is hardwired zero, so a load targeting it can never create a hazard
  assign o_loadUse = i_exMemRead && (i_exRegDest != '0) &&
                     ((i_exRegDest == i_idRs) || (i_exRegDest == i_idRt) ||
                      (i_exRegDest == i_idRs1c));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                     |
// | Pipeline stall/flush/freeze controller. Define HAZARD_PERF_CNT_EN to |
// | build the saturating stall/flush performance counters.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rs1c,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_regDest,
  input  logic                  branch_taken,
  input  logic                  mem_wait,
  output logic                  pc_write,
  output logic                  ifid_regWrite,
  output logic                  idex_regWrite,
  output logic                  exmem_regWrite,
  output logic                  memwb_regWrite,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [INIT_CNT_W-1:0] C_INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [INIT_CNT_W-1:0] r_initCnt;
  logic [INIT_CNT_W-1:0] w_nextInitCnt;
  logic                  r_pendFlush;
  logic                  w_nextPendFlush;
  logic                  w_loadUse;

  hazard_detect u_hazardDetect (
    .i_idRs      (id_rs),
    .i_idRt      (id_rt),
    .i_idRs1c    (id_rs1c),
    .i_exMemRead (ex_memRead),
    .i_exRegDest (ex_regDest),
    .o_loadUse   (w_loadUse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= INIT;
      r_initCnt   <= '0;
      r_pendFlush <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_initCnt   <= w_nextInitCnt;
      r_pendFlush <= w_nextPendFlush;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextInitCnt   = r_initCnt;
    w_nextPendFlush = r_pendFlush;
    pc_write        = 1'b1;
    ifid_regWrite   = 1'b1;
    idex_regWrite   = 1'b1;
    exmem_regWrite  = 1'b1;
    memwb_regWrite  = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;

    unique case (r_state)
      INIT: begin
        pc_write       = 1'b0;
        ifid_regWrite  = 1'b0;
        idex_regWrite  = 1'b0;
        exmem_regWrite = 1'b0;
        memwb_regWrite = 1'b0;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
        if (r_initCnt == C_INIT_LAST) begin
          w_nextState   = RUN;
          w_nextInitCnt = '0;
        end else begin
          w_nextInitCnt = r_initCnt + 1'b1;
        end
      end
      RUN, FREEZE: begin
        if (mem_wait) begin
          pc_write       = 1'b0;
          ifid_regWrite  = 1'b0;
          idex_regWrite  = 1'b0;
          exmem_regWrite = 1'b0;
          memwb_regWrite = 1'b0;
          w_nextState    = FREEZE;
          // A redirect during a freeze must survive until the pipeline moves
          if (branch_taken) w_nextPendFlush = 1'b1;
        end else begin
          w_nextState = RUN;
          if (branch_taken || r_pendFlush) begin
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            w_nextPendFlush = 1'b0;
          end else if (w_loadUse) begin
            pc_write      = 1'b0;
            ifid_regWrite = 1'b0;
            idex_flush    = 1'b1;
          end
        end
      end
      default: begin
        w_nextState   = INIT;
        w_nextInitCnt = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             w_active;
  logic             w_stallEv;
  logic             w_flushEv;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  assign w_active  = (r_state == RUN) || (r_state == FREEZE);
  assign w_stallEv = w_active && (mem_wait ||
                     (!(branch_taken || r_pendFlush) && w_loadUse));
  assign w_flushEv = w_active && !mem_wait && (branch_taken || r_pendFlush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallEv && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
      if (w_flushEv && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign stall_count = r_stallCnt;
  assign flush_count = r_flushCnt;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                  |
// | Scoreboard bench with a cycle-level reference model of the control.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_rs1c = '0, ex_regDest = '0;
  logic       ex_memRead = 1'b0, branch_taken = 1'b0, mem_wait = 1'b0;
  logic       pc_write, ifid_regWrite, idex_regWrite, exmem_regWrite, memwb_regWrite;
  logic       ifid_flush, idex_flush;
  logic [15:0] stall_count, flush_count;

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs1c        (id_rs1c),
    .ex_memRead     (ex_memRead),
    .ex_regDest     (ex_regDest),
    .branch_taken   (branch_taken),
    .mem_wait       (mem_wait),
    .pc_write       (pc_write),
    .ifid_regWrite  (ifid_regWrite),
    .idex_regWrite  (idex_regWrite),
    .exmem_regWrite (exmem_regWrite),
    .memwb_regWrite (memwb_regWrite),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  // ctrl = {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush}
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int initLeft = 4;
  bit pend = 0;
  int sCnt = 0;
  int fCnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict the outputs, advance the model
  task automatic step(input bit rst, input bit mr, input int dest, input int rs,
                      input int rt, input int rs1c, input bit bt, input bit mw);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset = rst; ex_memRead = mr; ex_regDest = dest[4:0];
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_rs1c = rs1c[4:0];
    branch_taken = bt; mem_wait = mw;

    if (rst) begin
      initLeft = 4; pend = 0; sCnt = 0; fCnt = 0;
    end
    e.sc = 16'(sCnt);
    e.fc = 16'(fCnt);
`ifndef HAZARD_PERF_CNT_EN
    e.sc = 16'h0;
    e.fc = 16'h0;
`endif
    lu = mr && (dest != 0) && (dest == rs || dest == rt || dest == rs1c);
    if (rst) begin
      e.ctrl = 7'b0000011;
    end else if (initLeft > 0) begin
      e.ctrl = 7'b0000011;
      initLeft--;
    end else if (mw) begin
      e.ctrl = 7'b0000000;
      if (bt) pend = 1;
      if (sCnt < 65535) sCnt++;
    end else if (bt || pend) begin
      e.ctrl = 7'b1111111;
      pend = 0;
      if (fCnt < 65535) fCnt++;
    end else if (lu) begin
      e.ctrl = 7'b0011101;
      if (sCnt < 65535) sCnt++;
    end else begin
      e.ctrl = 7'b1111100;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle with the oldest prediction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctrl", {9'b0, pc_write, ifid_regWrite, idex_regWrite, exmem_regWrite,
                   memwb_regWrite, ifid_flush, idex_flush}, {9'b0, e.ctrl});
      chk("stall_count", stall_count, e.sc);
      chk("flush_count", flush_count, e.fc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit %0d", $time, 1_000_000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset pulse then idle: four INIT cycles, then normal running
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Load-use on rt, then the same with destination r0
    step(0, 1, 5, 0, 5, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 9, 1, 2, 9, 0, 0);
    idle(1);

    // Branch overrides a simultaneous load-use
    step(0, 1, 7, 7, 0, 0, 1, 0);
    idle(1);

    // Freeze for three cycles with a branch in the middle
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Reset while frozen with a pending flush: the flush must be forgotten
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(6);

    // Hazard inputs and mem_wait during INIT are ignored
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 3, 3, 3, 1, 1);
    step(0, 1, 3, 3, 3, 3, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Randomized traffic with a narrow register range to provoke matches
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) == 0);
    end
    idle(2);

    // Long freeze to drive the stall counter into saturation
    for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 4, 4, 0, 0, 0, 0);
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single pipeline clock; all state on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: id_rs, id_rt, id_rs1c  in  5 each  source register numbers of the instruction in ID (ALU slot rs/rt, second slot rs1c).
REQ-004 SHALL: ex_memRead  in  1  instruction in EX is a load; ex_regDest  in  5  its destination.
REQ-005 SHALL: branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-006 SHALL: mem_wait  in  1  data memory needs another cycle; whole pipeline must hold.
REQ-007 SHALL: pc_write, ifid_regWrite, idex_regWrite, exmem_regWrite, memwb_regWrite  out  1 each  write enables to the PC and the four pipeline registers.
REQ-008 SHALL: ifid_flush, idex_flush  out  1 each  synchronous clear (bubble) for IF_ID and ID_EX.
REQ-009 SHALL: stall_count, flush_count  out  16 each  performance counters (see Configuration).

Function
REQ-010 SHALL: FSM states INIT, RUN, FREEZE.
REQ-011 SHALL: INIT lasts exactly INIT_CYCLES=4 cycles after reset release; all *_regWrite=0, pc_write=0, both flushes=1; then RUN.
REQ-012 SHALL: load_use = ex_memRead && ex_regDest!=0 && ex_regDest matches any of id_rs, id_rt, id_rs1c (combinational).
REQ-013 SHALL: RUN, no event: all enables=1, flushes=0.
REQ-014 SHALL: RUN, load_use and not branch_taken: same cycle pc_write=0, ifid_regWrite=0, idex_flush=1, exmem/memwb enables=1; 1 cycle penalty, rechecked each cycle.
REQ-015 SHALL: RUN, branch_taken: ifid_flush=1, idex_flush=1, all enables=1; branch_taken overrides load_use.
REQ-016 SHALL: mem_wait=1 in RUN: all enables=0, flushes=0 same cycle; next state FREEZE.
REQ-017 SHALL: FREEZE: all enables=0, flushes=0 while mem_wait=1; mem_wait=0 returns to RUN same cycle (outputs follow REQ-013..015).
REQ-018 SHALL: branch_taken seen while mem_wait=1 is latched in pend_flush; first cycle with mem_wait=0 applies REQ-015 flush even if branch_taken has dropped; pend_flush then clears.
REQ-019 SHALL: priority mem_wait > (branch_taken | pend_flush) > load_use.
REQ-020 SHALL: hazard inputs ignored in INIT; mem_wait in INIT does not extend INIT.

Reset
REQ-021 SHALL: reset asserted: state=INIT, init counter=0, pend_flush=0, counters=0; outputs immediately take INIT values (enables 0, flushes 1).
REQ-022 SHALL: reset mid-FREEZE or mid-stall discards pending flush and restarts INIT from cycle 0.

Configuration
REQ-023 SHALL: macro HAZARD_PERF_CNT_EN defined: stall_count increments each cycle REQ-014 or FREEZE applies, flush_count each cycle REQ-015/018 applies; both saturate at 16'hFFFF; not counted in INIT.
REQ-024 SHALL: macro undefined: counter logic absent, stall_count and flush_count driven constant 0, ports retained.

Structure
REQ-025 SHALL: shared package pipe_ctrl_pkg holds state enum, INIT_CYCLES=4, REG_ADDR_W=5, CNT_W=16.
REQ-026 SHALL: combinational compare of REQ-012 in sub-module hazard_detect, instantiated once.

Verification
REQ-027 SHALL: reset pulse then 6 idle cycles -> 4 cycles enables=0/flushes=1, then all enables=1, flushes=0.
REQ-028 SHALL: ex_memRead=1, ex_regDest=5, id_rt=5 for 1 cycle -> pc_write=0, ifid_regWrite=0, idex_flush=1 that cycle; stall_count=1 with macro; same with ex_regDest=0 -> no stall.
REQ-029 SHALL: branch_taken=1 with simultaneous load_use (regDest=7=id_rs) -> ifid_flush=idex_flush=1, pc_write=1; flush_count=1, stall_count=0.
REQ-030 SHALL: mem_wait=1 for 3 cycles, branch_taken pulsed in 2nd -> 3 cycles all enables=0, 4th cycle both flushes=1, 5th normal.
REQ-031 SHALL: reset asserted during FREEZE with pend_flush set -> outputs to INIT values without clock edge; after 4 INIT cycles no flush applied.
REQ-032 SHALL: force 65540 stall cycles with macro -> stall_count holds 16'hFFFF; without macro -> 0 throughout.
